// File: rtl/freq_meter.sv
// freq_meter: gated edge counter and last-period meter referenced to CLOCK_50MHZ.
// Rising edges of SIGNAL_IN are synchronized, then counted over a GATE_CYCLES window.
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 32'h2FAF080,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   CLOCK_50MHZ,
    input  logic                   RESET_N,
    input  logic                   SIGNAL_IN,
    input  logic                   START,
    output logic [COUNT_WIDTH-1:0] FREQ,
    output logic [COUNT_WIDTH-1:0] PERIOD,
    output logic                   VALID,
    output logic                   BUSY,
    output logic                   OVERFLOW
);

    localparam int unsigned GATE_WIDTH = $clog2(GATE_CYCLES + 1);

    localparam logic [GATE_WIDTH-1:0]  GATE_LAST = GATE_WIDTH'(GATE_CYCLES);
    localparam logic [GATE_WIDTH-1:0]  GATE_ONE  = GATE_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GATE = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [2:0]             sync_q;
    logic                   edge_det;
    logic [1:0]             state_q, state_d;
    logic                   start_gate;
    logic [GATE_WIDTH-1:0]  gate_cnt_q, gate_cnt_d;
    logic [COUNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [COUNT_WIDTH-1:0] period_cnt_q, period_cnt_d;
    logic [COUNT_WIDTH-1:0] period_res_q, period_res_d;
    logic                   edge_seen_q, edge_seen_d;
    logic                   ovf_q, ovf_d;
    logic [COUNT_WIDTH-1:0] freq_q, freq_d;
    logic [COUNT_WIDTH-1:0] period_q, period_d;
    logic                   ovf_out_q, ovf_out_d;

    // sync_q[1:0] is the two-flop synchronizer, sync_q[2] the previous sample
    always_ff @(posedge CLOCK_50MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1], sync_q[0], SIGNAL_IN};
        end
    end

    assign edge_det = sync_q[1] & ~sync_q[2];

    always_comb begin
        state_d      = state_q;
        start_gate   = 1'b0;
        gate_cnt_d   = gate_cnt_q;
        edge_cnt_d   = edge_cnt_q;
        period_cnt_d = period_cnt_q;
        period_res_d = period_res_q;
        edge_seen_d  = edge_seen_q;
        ovf_d        = ovf_q;
        freq_d       = freq_q;
        period_d     = period_q;
        ovf_out_d    = ovf_out_q;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d    = ST_GATE;
                    start_gate = 1'b1;
                end
            end
            ST_GATE: begin
                if (edge_det) begin
                    if (edge_cnt_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        edge_cnt_d = edge_cnt_q + CNT_ONE;
                    end
                    if (edge_seen_q) begin
                        period_res_d = period_cnt_q;
                    end
                    edge_seen_d  = 1'b1;
                    period_cnt_d = CNT_ONE;
                end else if (edge_seen_q) begin
                    if (period_cnt_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        period_cnt_d = period_cnt_q + CNT_ONE;
                    end
                end
                // Outputs take the next-state values so the final gate cycle is included
                if (gate_cnt_q == GATE_LAST) begin
                    state_d   = ST_DONE;
                    freq_d    = edge_cnt_d;
                    period_d  = period_res_d;
                    ovf_out_d = ovf_d;
                end else begin
                    gate_cnt_d = gate_cnt_q + GATE_ONE;
                end
            end
            ST_DONE: begin
                if (START) begin
                    state_d    = ST_GATE;
                    start_gate = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_gate) begin
            gate_cnt_d   = GATE_ONE;
            edge_cnt_d   = '0;
            period_cnt_d = '0;
            period_res_d = '0;
            edge_seen_d  = 1'b0;
            ovf_d        = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            gate_cnt_q   <= '0;
            edge_cnt_q   <= '0;
            period_cnt_q <= '0;
            period_res_q <= '0;
            edge_seen_q  <= 1'b0;
            ovf_q        <= 1'b0;
            freq_q       <= '0;
            period_q     <= '0;
            ovf_out_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            gate_cnt_q   <= gate_cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            period_cnt_q <= period_cnt_d;
            period_res_q <= period_res_d;
            edge_seen_q  <= edge_seen_d;
            ovf_q        <= ovf_d;
            freq_q       <= freq_d;
            period_q     <= period_d;
            ovf_out_q    <= ovf_out_d;
        end
    end

    assign FREQ     = freq_q;
    assign PERIOD   = period_q;
    assign OVERFLOW = ovf_out_q;
    assign VALID    = (state_q == ST_DONE);
    assign BUSY     = (state_q == ST_GATE);

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: a 32-bit and a 4-bit instance share one stimulus,
// both with a 1000-cycle gate.
module tb_freq_meter;

    logic        CLOCK_50MHZ = 1'b0;
    logic        RESET_N     = 1'b0;
    logic        SIGNAL_IN   = 1'b0;
    logic        START       = 1'b0;
    logic [31:0] freq_a, period_a;
    logic        valid_a, busy_a, ovf_a;
    logic [3:0]  freq_b, period_b;
    logic        valid_b, busy_b, ovf_b;

    int errors = 0;
    int checks = 0;

    int busy_cnt, busy_first, valid_cnt, valid_at;
    logic [31:0] fa, pa;
    logic        oa;
    logic [3:0]  fb, pb;
    logic        ob;

    freq_meter #(.GATE_CYCLES(1000), .COUNT_WIDTH(32)) dut_a (
        .CLOCK_50MHZ(CLOCK_50MHZ), .RESET_N(RESET_N), .SIGNAL_IN(SIGNAL_IN), .START(START),
        .FREQ(freq_a), .PERIOD(period_a), .VALID(valid_a), .BUSY(busy_a), .OVERFLOW(ovf_a)
    );

    freq_meter #(.GATE_CYCLES(1000), .COUNT_WIDTH(4)) dut_b (
        .CLOCK_50MHZ(CLOCK_50MHZ), .RESET_N(RESET_N), .SIGNAL_IN(SIGNAL_IN), .START(START),
        .FREQ(freq_b), .PERIOD(period_b), .VALID(valid_b), .BUSY(busy_b), .OVERFLOW(ovf_b)
    );

    always #10 CLOCK_50MHZ = ~CLOCK_50MHZ;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mode 0: constant level hi[0]; mode 1: period per, high for hi; mode 2: 10-cycle
    // pulses starting at e0/e1/e2
    function automatic logic pat(input int mode, input int per, input int hi, input int ph,
                                 input int e0, input int e1, input int e2, input int k);
        case (mode)
            0: return hi[0];
            1: return ((k + 100000 + ph) % per) < hi;
            default: return (k >= e0 && k < e0 + 10) || (k >= e1 && k < e1 + 10) ||
                            (k >= e2 && k < e2 + 10);
        endcase
    endfunction

    // START is high for the edge t only; cycle j is the cycle after edge t+j
    task automatic run_gate(input int mode, input int per, input int hi, input int ph,
                            input int e0, input int e1, input int e2);
        busy_cnt = 0; busy_first = 0; valid_cnt = 0; valid_at = 0;
        for (int k = -300; k <= 1010; k++) begin
            SIGNAL_IN = pat(mode, per, hi, ph, e0, e1, e2, k);
            START     = (k == 0);
            @(posedge CLOCK_50MHZ);
            #1;
            if (busy_a) begin
                busy_cnt++;
                if (busy_first == 0) busy_first = k + 1;
            end
            if (valid_a) begin
                valid_cnt++;
                valid_at = k + 1;
                fa = freq_a; pa = period_a; oa = ovf_a;
                fb = freq_b; pb = period_b; ob = ovf_b;
            end
        end
        START = 1'b0;
    endtask

    initial begin
        int vtimes[3];
        int ph;

        // Reset with random activity on the inputs
        RESET_N = 1'b0;
        for (int i = 0; i < 10; i++) begin
            SIGNAL_IN = 1'($urandom_range(0, 1));
            START     = 1'($urandom_range(0, 1));
            @(posedge CLOCK_50MHZ);
            #1;
        end
        check("rst_freq", freq_a, 0);
        check("rst_period", period_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_ovf", ovf_a, 0);
        START = 1'b0;
        SIGNAL_IN = 1'b0;
        RESET_N = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLOCK_50MHZ);
            #1;
            if (busy_a) busy_cnt++;
        end
        check("idle_busy", busy_cnt, 0);

        // Periodic 50/50, random phase
        ph = $urandom_range(0, 99);
        run_gate(1, 100, 50, ph, 0, 0, 0);
        check("per_busy_cnt", busy_cnt, 1000);
        check("per_busy_first", busy_first, 1);
        check("per_valid_cnt", valid_cnt, 1);
        check("per_valid_at", valid_at, 1001);
        check("per_freq", fa, 10);
        check("per_period", pa, 100);
        check("per_ovf", oa, 0);

        // Constant high
        run_gate(0, 1, 1, 0, 0, 0, 0);
        check("const_freq", fa, 0);
        check("const_period", pa, 0);

        // Single edge mid-gate
        run_gate(2, 1, 0, 0, 400, -5000, -5000);
        check("one_freq", fa, 1);
        check("one_period", pa, 0);

        // Edges spaced 37 then 120
        run_gate(2, 1, 0, 0, 100, 137, 257);
        check("sp_freq", fa, 3);
        check("sp_period", pa, 120);

        // Period 4: saturates the 4-bit edge counter
        run_gate(1, 4, 2, 0, 0, 0, 0);
        check("ov_freq_b", fb, 15);
        check("ov_ovf_b", ob, 1);
        check("ov_period_b", pb, 4);
        check("ov_freq_a", fa, 250);
        check("ov_period_a", pa, 4);
        check("ov_ovf_a", oa, 0);

        // Next gate idle clears the overflow
        run_gate(0, 1, 0, 0, 0, 0, 0);
        check("idle_freq_b", fb, 0);
        check("idle_ovf_b", ob, 0);
        check("idle_valid_cnt", valid_cnt, 1);

        // Back-to-back gates, START dropped during the third gate
        busy_cnt = 0; valid_cnt = 0;
        for (int k = -300; k <= 3020; k++) begin
            SIGNAL_IN = pat(1, 200, 100, 0, 0, 0, 0, k);
            START     = (k >= 0 && k <= 2500);
            @(posedge CLOCK_50MHZ);
            #1;
            if (busy_a) busy_cnt++;
            if (valid_a) begin
                if (valid_cnt < 3) vtimes[valid_cnt] = k + 1;
                valid_cnt++;
                check("b2b_freq", freq_a, 5);
                check("b2b_period", period_a, 200);
            end
        end
        START = 1'b0;
        check("b2b_valid_cnt", valid_cnt, 3);
        check("b2b_v0", vtimes[0], 1001);
        check("b2b_v1", vtimes[1], 2002);
        check("b2b_v2", vtimes[2], 3003);
        check("b2b_busy_cnt", busy_cnt, 3000);
        check("b2b_ovf_b", ovf_b, 1);

        // Reset at gate cycle 500
        for (int k = 0; k < 500; k++) begin
            SIGNAL_IN = pat(1, 100, 50, 0, 0, 0, 0, k);
            START     = (k == 0);
            @(posedge CLOCK_50MHZ);
            #1;
        end
        START = 1'b0;
        check("mid_busy_before", busy_a, 1);
        RESET_N = 1'b0;
        #1;
        check("mid_freq", freq_a, 0);
        check("mid_period", period_a, 0);
        check("mid_busy", busy_a, 0);
        check("mid_valid", valid_a, 0);
        check("mid_ovf_b", ovf_b, 0);
        for (int i = 0; i < 3; i++) @(posedge CLOCK_50MHZ);
        #1;
        RESET_N = 1'b1;

        ph = $urandom_range(0, 99);
        run_gate(1, 100, 50, ph, 0, 0, 0);
        check("post_busy_cnt", busy_cnt, 1000);
        check("post_valid_at", valid_at, 1001);
        check("post_freq", fa, 10);
        check("post_period", pa, 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
# freq_meter

Gated frequency and period meter clocked from the 50 MHz board clock. It counts rising edges of an asynchronous input over a programmable gate window and reports the edge count, which equals the frequency in Hz for a 1 s gate. It also reports the period of the most recent input cycle, in reference-clock cycles. It is the measuring end of the clock-divider chain: it checks divided clocks, or any external slow signal, against CLOCK_50MHZ.

## Interface
- GATE_CYCLES, default 50000000 (32'h2FAF080, 1 s gate), gate length in CLOCK_50MHZ cycles, must be ≥ 2
- COUNT_WIDTH, default 32, width of FREQ, PERIOD and the internal counters
- CLOCK_50MHZ  input  1  reference clock, all logic on posedge
- RESET_N  input  1  reset, asynchronous, active-low
- SIGNAL_IN  input  1  signal under measurement, asynchronous to CLOCK_50MHZ
- START  input  1  level; sampled in IDLE and DONE, starts a gate when high
- FREQ  output  COUNT_WIDTH  rising edges counted in last completed gate
- PERIOD  output  COUNT_WIDTH  cycles between last two counted edges of last gate
- VALID  output  1  one-cycle pulse when FREQ/PERIOD/OVERFLOW update
- BUSY  output  1  high while in GATE
- OVERFLOW  output  1  last gate saturated the edge or period counter

## Operation
- Input path: 2-flop synchronizer, then a third flop holds the previous value.
  - Edge detect = stage2 & ~stage3.
  - All three flops reset to 0.
- FSM states:
  - IDLE: BUSY=0. START=1 moves to GATE.
  - GATE: BUSY=1. The gate counter runs 1..GATE_CYCLES. Leave to DONE when it equals GATE_CYCLES.
  - DONE: VALID=1 for this single cycle. START=1 moves to GATE, otherwise to IDLE.
- Entering GATE clears the edge counter, the period counter, the edge-seen flag, the period result and the overflow flag.
- Edge counter: increments on each edge detected during a GATE cycle. It saturates at all-ones and sets overflow.
- Period tracking:
  - After the first edge in a gate, the period counter counts cycles.
  - On each later edge, the distance (cycles between the two detections) is latched and the counter restarts.
  - The period counter saturates at all-ones and sets overflow.
  - With fewer than 2 edges in a gate, PERIOD = 0.
- Output registers FREQ, PERIOD and OVERFLOW load on the GATE→DONE transition and hold until the next GATE→DONE.
- Edges detected in IDLE or DONE cycles are ignored.
- Edges detected on the final GATE cycle are counted.
- RESET_N low at any time, including mid-gate, immediately forces:
  - IDLE state;
  - FREQ=0, PERIOD=0, VALID=0, BUSY=0, OVERFLOW=0;
  - all counters 0.

## Timing
- START high at rising edge t (in IDLE) gives:
  - BUSY=1 from t+1 for exactly GATE_CYCLES cycles;
  - VALID=1 and new outputs in cycle t+GATE_CYCLES+1.
- START held high: back-to-back gates, VALID every GATE_CYCLES+1 cycles. The DONE cycle is a dead cycle where edges are not counted.
- Input latency:
  - SIGNAL_IN rising before edge k → edge detect high in the cycle after edge k+1, counted at edge k+2.
  - Minimum resolvable input: high ≥ 2 cycles and low ≥ 2 cycles. Faster inputs give undefined counts.
- Because the gate window is half-open, a strictly periodic input of period P with GATE_CYCLES a multiple of P yields exactly GATE_CYCLES/P edges, independent of phase.
- Release of RESET_N is synchronous to the design; the first START is honoured on the first clock edge after release.

## Test plan
- Reset: drive RESET_N=0 with random SIGNAL_IN/START → FREQ=0, PERIOD=0, VALID=0, BUSY=0, OVERFLOW=0. After release with START=0 → BUSY stays 0.
- Periodic input: GATE_CYCLES=1000, SIGNAL_IN 50 high/50 low, random phase, START pulse at t:
  - BUSY high t+1..t+1000;
  - VALID only at t+1001;
  - FREQ=10, PERIOD=100, OVERFLOW=0.
- Degenerate inputs, GATE_CYCLES=1000:
  - SIGNAL_IN constant 1 → FREQ=0, PERIOD=0.
  - Exactly one rising edge mid-gate → FREQ=1, PERIOD=0.
  - Edges spaced 37 then 120 cycles → FREQ=3, PERIOD=120.
- Overflow: COUNT_WIDTH=4, GATE_CYCLES=1000, SIGNAL_IN period 4 → FREQ=15, OVERFLOW=1. The next gate with SIGNAL_IN idle → FREQ=0, OVERFLOW=0.
- Back-to-back: START held high, GATE_CYCLES=1000, period 200 input:
  - VALID pulses exactly 1001 cycles apart, each with FREQ=5, PERIOD=200;
  - deassert START → returns to IDLE after the next DONE.
- Reset mid-gate: assert RESET_N=0 at gate cycle 500 → outputs 0 and BUSY=0 immediately. After release, a new START gives a full-length gate with a correct result.
